// File: rtl/decode_stage.sv
// decode_stage: registered MIPS instruction-decode stage between fetch and execute.
// Decodes opcode/funct into ALU select/op, register indices, extended immediate and
// control flags; valid/ready on both sides, 1- or 2-entry buffering, synchronous flush.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds out_illegal and sticky illegal_seen.
module decode_stage #(
  parameter int PC_WIDTH     = 32,
  parameter int SKID_DEPTH   = 2,
  parameter int ALU_OP_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             in_inst,
  input  logic [PC_WIDTH-1:0]     in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PC_WIDTH-1:0]     out_pc,
  output logic [2:0]              out_alu_sel,
  output logic [ALU_OP_WIDTH-1:0] out_alu_op,
  output logic [4:0]              out_rs,
  output logic [4:0]              out_rt,
  output logic [4:0]              out_rd,
  output logic [4:0]              out_shamt,
  output logic [31:0]             out_imm,
  output logic                    out_reg_write,
  output logic                    out_mem_read,
  output logic                    out_mem_write,
  output logic                    out_is_branch,
  output logic                    out_is_jump
`ifdef DECODE_ILLEGAL_TRAP_EN
  ,output logic                   out_illegal,
  output logic                    illegal_seen
`endif
);

  localparam logic [2:0] SEL_LOGIC = 3'd0;
  localparam logic [2:0] SEL_SHIFT = 3'd1;
  localparam logic [2:0] SEL_ARITH = 3'd2;
  localparam logic [2:0] SEL_JUMP  = 3'd3;
  localparam logic [2:0] SEL_LS    = 3'd4;

  localparam logic [ALU_OP_WIDTH-1:0] OP_OR   = ALU_OP_WIDTH'(0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND  = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR  = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NOR  = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LUI  = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLL  = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRL  = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD  = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] OP_JAL  = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_BEQ  = ALU_OP_WIDTH'(9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LW   = ALU_OP_WIDTH'(10);
  localparam logic [ALU_OP_WIDTH-1:0] OP_LB   = ALU_OP_WIDTH'(11);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SB   = ALU_OP_WIDTH'(12);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SW   = ALU_OP_WIDTH'(13);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB  = ALU_OP_WIDTH'(14);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SLT  = ALU_OP_WIDTH'(15);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA  = ALU_OP_WIDTH'(16);
  localparam logic [ALU_OP_WIDTH-1:0] OP_BNE  = ALU_OP_WIDTH'(17);
  localparam logic [ALU_OP_WIDTH-1:0] OP_BGTZ = ALU_OP_WIDTH'(18);
  localparam logic [ALU_OP_WIDTH-1:0] OP_J    = ALU_OP_WIDTH'(19);
  localparam logic [ALU_OP_WIDTH-1:0] OP_JR   = ALU_OP_WIDTH'(20);
  localparam logic [ALU_OP_WIDTH-1:0] OP_NOP  = ALU_OP_WIDTH'(21);

  // Jump targets are cut down to the implemented pc width
  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFF >> (32 - PC_WIDTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]     pc;
    logic [2:0]              sel;
    logic [ALU_OP_WIDTH-1:0] op;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              rd;
    logic [4:0]              shamt;
    logic [31:0]             imm;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    is_branch;
    logic                    is_jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                    illegal;
`endif
  } entry_t;

  entry_t              w_dec;
  logic                w_wr_en;
  logic [5:0]          w_opcode;
  logic [5:0]          w_funct;
  logic [15:0]         w_imm16;
  logic [31:0]         w_zext;
  logic [31:0]         w_sext;
  logic [PC_WIDTH-1:0] w_pc4;
  logic [31:0]         w_pc4_ext;
  logic [31:0]         w_jtarget;
  logic                w_in_xfer;
  logic                w_out_xfer;
  entry_t              r_main;
  logic                r_main_valid;

  assign w_opcode  = in_inst[31:26];
  assign w_funct   = in_inst[5:0];
  assign w_imm16   = in_inst[15:0];
  assign w_zext    = {16'h0, w_imm16};
  assign w_sext    = {{16{w_imm16[15]}}, w_imm16};
  assign w_pc4     = in_pc + PC_WIDTH'(4);
  assign w_pc4_ext = 32'(w_pc4);
  assign w_jtarget = ((w_pc4_ext & 32'hF000_0000) | {4'h0, in_inst[25:0], 2'b00}) & PC_MASK;

  // Combinational decode of the offered instruction; inst==0 and unknown encodings stay NOP
  always_comb begin
    w_dec       = '0;
    w_dec.pc    = in_pc;
    w_dec.rs    = in_inst[25:21];
    w_dec.rt    = in_inst[20:16];
    w_dec.sel   = SEL_SHIFT;
    w_dec.op    = OP_NOP;
    w_wr_en     = 1'b0;
    if (in_inst != 32'h0) begin
      if (w_opcode == 6'h00) begin
        w_dec.rd = in_inst[15:11];
        w_wr_en  = 1'b1;
        case (w_funct)
          6'h00: begin w_dec.op = OP_SLL; w_dec.shamt = in_inst[10:6]; end
          6'h02: begin w_dec.op = OP_SRL; w_dec.shamt = in_inst[10:6]; end
          6'h03: begin w_dec.op = OP_SRA; w_dec.shamt = in_inst[10:6]; end
          6'h08: begin
            w_dec.sel = SEL_JUMP; w_dec.op = OP_JR; w_dec.is_jump = 1'b1;
            w_dec.rd = 5'd0; w_wr_en = 1'b0;
          end
          6'h20, 6'h21: begin w_dec.sel = SEL_ARITH; w_dec.op = OP_ADD; end
          6'h22, 6'h23: begin w_dec.sel = SEL_ARITH; w_dec.op = OP_SUB; end
          6'h24: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_AND; end
          6'h25: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_OR;  end
          6'h26: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_XOR; end
          6'h27: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_NOR; end
          6'h2A: begin w_dec.sel = SEL_ARITH; w_dec.op = OP_SLT; end
          default: begin
            w_dec.rd = 5'd0; w_wr_en = 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_dec.illegal = 1'b1;
`endif
          end
        endcase
      end else begin
        case (w_opcode)
          6'h02: begin w_dec.sel = SEL_JUMP; w_dec.op = OP_J; w_dec.imm = w_jtarget; w_dec.is_jump = 1'b1; end
          6'h03: begin
            w_dec.sel = SEL_JUMP; w_dec.op = OP_JAL; w_dec.imm = w_jtarget; w_dec.is_jump = 1'b1;
            w_dec.rd = 5'd31; w_wr_en = 1'b1;
          end
          6'h04: begin w_dec.sel = SEL_JUMP; w_dec.op = OP_BEQ;  w_dec.imm = {w_sext[29:0], 2'b00}; w_dec.is_branch = 1'b1; end
          6'h05: begin w_dec.sel = SEL_JUMP; w_dec.op = OP_BNE;  w_dec.imm = {w_sext[29:0], 2'b00}; w_dec.is_branch = 1'b1; end
          6'h07: begin w_dec.sel = SEL_JUMP; w_dec.op = OP_BGTZ; w_dec.imm = {w_sext[29:0], 2'b00}; w_dec.is_branch = 1'b1; end
          6'h09: begin w_dec.sel = SEL_ARITH; w_dec.op = OP_ADD; w_dec.imm = w_sext; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h0C: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_AND; w_dec.imm = w_zext; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h0D: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_OR;  w_dec.imm = w_zext; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h0E: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_XOR; w_dec.imm = w_zext; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h0F: begin w_dec.sel = SEL_LOGIC; w_dec.op = OP_LUI; w_dec.imm = {w_imm16, 16'h0}; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h20: begin w_dec.sel = SEL_LS; w_dec.op = OP_LB; w_dec.imm = w_sext; w_dec.mem_read = 1'b1; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h23: begin w_dec.sel = SEL_LS; w_dec.op = OP_LW; w_dec.imm = w_sext; w_dec.mem_read = 1'b1; w_dec.rd = in_inst[20:16]; w_wr_en = 1'b1; end
          6'h28: begin w_dec.sel = SEL_LS; w_dec.op = OP_SB; w_dec.imm = w_sext; w_dec.mem_write = 1'b1; end
          6'h2B: begin w_dec.sel = SEL_LS; w_dec.op = OP_SW; w_dec.imm = w_sext; w_dec.mem_write = 1'b1; end
          default: begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            w_dec.illegal = 1'b1;
`endif
          end
        endcase
      end
    end
    // Writes to r0 are dropped
    w_dec.reg_write = w_wr_en && (w_dec.rd != 5'd0);
  end

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_main_valid && out_ready;

  generate
    if (SKID_DEPTH == 1) begin : g_single
      assign in_ready = rst_n && (!r_main_valid || out_ready);

      // Single entry: a capture replaces the entry, an output transfer alone empties it
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main       <= '0;
          r_main_valid <= 1'b0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_main       <= w_dec;
          r_main_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_main_valid <= 1'b0;
        end
      end
    end else begin : g_skid
      entry_t r_skid;
      logic   r_skid_valid;

      // Ready depends only on skid occupancy, so it comes straight from a flop
      assign in_ready = rst_n && !r_skid_valid;

      // Main/skid pair: skid fills only while main is stalled and drains first (FIFO)
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main       <= '0;
          r_main_valid <= 1'b0;
          r_skid       <= '0;
          r_skid_valid <= 1'b0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_out_xfer) begin
          if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
          end else begin
            r_main_valid <= 1'b0;
          end
        end else if (w_in_xfer) begin
          r_skid       <= w_dec;
          r_skid_valid <= 1'b1;
        end
      end
    end
  endgenerate

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic r_illegal_seen;

  // Sticky record of any captured unknown encoding; only reset clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal_seen <= 1'b0;
    end else if (w_in_xfer && !flush && w_dec.illegal) begin
      r_illegal_seen <= 1'b1;
    end
  end

  assign out_illegal  = r_main.illegal;
  assign illegal_seen = r_illegal_seen;
`endif

  assign out_valid     = r_main_valid;
  assign out_pc        = r_main.pc;
  assign out_alu_sel   = r_main.sel;
  assign out_alu_op    = r_main.op;
  assign out_rs        = r_main.rs;
  assign out_rt        = r_main.rt;
  assign out_rd        = r_main.rd;
  assign out_shamt     = r_main.shamt;
  assign out_imm       = r_main.imm;
  assign out_reg_write = r_main.reg_write;
  assign out_mem_read  = r_main.mem_read;
  assign out_mem_write = r_main.mem_write;
  assign out_is_branch = r_main.is_branch;
  assign out_is_jump   = r_main.is_jump;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// rule-level reference model and an occupancy/FIFO model of the stage.
module tb_decode_stage;
  localparam int PCW  = 32;
  localparam int SKID = 2;
  localparam int OPW  = 8;
  localparam logic [31:0] PCMASK = 32'hFFFF_FFFF >> (32 - PCW);

  typedef struct packed {
    logic [31:0] pc;
    logic [2:0]  sel;
    logic [7:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm;
    logic        rw, mr, mw, br, jp;
    logic        ill;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_inst = '0;
  logic [PCW-1:0] in_pc = '0;
  logic [PCW-1:0] out_pc;
  logic [2:0] out_alu_sel;
  logic [OPW-1:0] out_alu_op;
  logic [4:0] out_rs, out_rt, out_rd, out_shamt;
  logic [31:0] out_imm;
  logic out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic out_illegal, illegal_seen;
`endif

  int compared = 0, mismatched = 0;
  exp_t q[$];
  logic seen_m = 1'b0;
  int obs_acc, obs_out;

  string names[22] = '{"OR","AND","XOR","NOR","LUI","SLL","SRL","ADD","JAL","BEQ","LW",
                       "LB","SB","SW","SUB","SLT","SRA","BNE","BGTZ","J","JR","NOP"};
  int legal_ops[14] = '{2, 3, 4, 5, 7, 9, 12, 13, 14, 15, 32, 35, 40, 43};
  int legal_fn[13]  = '{0, 2, 3, 8, 32, 33, 34, 35, 36, 37, 38, 39, 42};

  decode_stage #(.PC_WIDTH(PCW), .SKID_DEPTH(SKID), .ALU_OP_WIDTH(OPW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_alu_sel(out_alu_sel), .out_alu_op(out_alu_op),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
    .out_imm(out_imm), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_is_branch(out_is_branch), .out_is_jump(out_is_jump)
`ifdef DECODE_ILLEGAL_TRAP_EN
    , .out_illegal(out_illegal), .illegal_seen(illegal_seen)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference decode written from the instruction-set rules
  function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    string m, base;
    logic [5:0] opc, fn;
    e = '0; e.pc = pc; e.rs = inst[25:21]; e.rt = inst[20:16];
    opc = inst[31:26]; fn = inst[5:0]; m = "NOP";
    if (inst != 32'h0) begin
      if (opc == 6'h00) begin
        case (fn)
          6'h00: m = "SLL";  6'h02: m = "SRL";  6'h03: m = "SRA";  6'h08: m = "JR";
          6'h20: m = "ADD";  6'h21: m = "ADDU"; 6'h22: m = "SUB";  6'h23: m = "SUBU";
          6'h24: m = "AND";  6'h25: m = "OR";   6'h26: m = "XOR";  6'h27: m = "NOR";
          6'h2A: m = "SLT";
          default: e.ill = 1'b1;
        endcase
      end else begin
        case (opc)
          6'h02: m = "J";     6'h03: m = "JAL";  6'h04: m = "BEQ";  6'h05: m = "BNE";
          6'h07: m = "BGTZ";  6'h09: m = "ADDIU"; 6'h0C: m = "ANDI"; 6'h0D: m = "ORI";
          6'h0E: m = "XORI";  6'h0F: m = "LUI";  6'h20: m = "LB";   6'h23: m = "LW";
          6'h28: m = "SB";    6'h2B: m = "SW";
          default: e.ill = 1'b1;
        endcase
      end
    end
    base = m;
    if (m == "ORI") base = "OR";
    else if (m == "ANDI") base = "AND";
    else if (m == "XORI") base = "XOR";
    else if (m == "ADDU" || m == "ADDIU") base = "ADD";
    else if (m == "SUBU") base = "SUB";
    for (int i = 0; i < 22; i++) if (names[i] == base) e.op = 8'(i);
    if (e.op <= 8'd4) e.sel = 3'd0;
    else if (base == "SLL" || base == "SRL" || base == "SRA" || base == "NOP") e.sel = 3'd1;
    else if (base == "ADD" || base == "SUB" || base == "SLT") e.sel = 3'd2;
    else if (base == "LW" || base == "LB" || base == "SB" || base == "SW") e.sel = 3'd4;
    else e.sel = 3'd3;
    if (opc == 6'h00 && m != "NOP" && m != "JR") e.rd = inst[15:11];
    else if (m == "ADDIU" || m == "ANDI" || m == "ORI" || m == "XORI" || m == "LUI" ||
             m == "LB" || m == "LW") e.rd = inst[20:16];
    else if (m == "JAL") e.rd = 5'd31;
    e.rw = (e.rd != 5'd0);
    if (base == "SLL" || base == "SRL" || base == "SRA") e.shamt = inst[10:6];
    if (m == "ANDI" || m == "ORI" || m == "XORI") e.imm = 32'(inst[15:0]);
    else if (m == "ADDIU" || e.sel == 3'd4) e.imm = 32'(int'($signed(inst[15:0])));
    else if (m == "LUI") e.imm = 32'(inst[15:0]) * 32'h1_0000;
    else if (m == "BEQ" || m == "BNE" || m == "BGTZ") e.imm = 32'(int'($signed(inst[15:0])) * 4);
    else if (m == "J" || m == "JAL")
      e.imm = ((((pc + 32'd4) & PCMASK) & 32'hF000_0000) + 32'(inst[25:0]) * 32'd4) & PCMASK;
    e.mr = (m == "LB" || m == "LW");
    e.mw = (m == "SB" || m == "SW");
    e.br = (m == "BEQ" || m == "BNE" || m == "BGTZ");
    e.jp = (m == "J" || m == "JAL" || m == "JR");
    return e;
  endfunction

  function automatic logic [99:0] exp_vec(input exp_t e);
    return {e.pc, e.sel, e.op, e.rs, e.rt, e.rd, e.shamt, e.imm, e.rw, e.mr, e.mw, e.br, e.jp};
  endfunction

  function automatic logic [99:0] obs_vec();
    return {32'(out_pc), out_alu_sel, out_alu_op, out_rs, out_rt, out_rd, out_shamt, out_imm,
            out_reg_write, out_mem_read, out_mem_write, out_is_branch, out_is_jump};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 31);
    if (k < 13) begin w[31:26] = 6'h00; w[5:0] = 6'(legal_fn[k]); end
    else if (k < 27) w[31:26] = 6'(legal_ops[k-13]);
    else if (k == 27) w = 32'h0;
    if (w != 32'h0 && $urandom_range(0, 7) == 0) w[20:11] = 10'h0;
    return w;
  endfunction

  // One clock of stimulus: drive, compare against the model, then advance the model
  task automatic cycle(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    logic exp_ready;
    @(negedge clk);
    in_valid = v; in_inst = inst; in_pc = pc[PCW-1:0]; out_ready = ordy; flush = fl;
    #1;
    exp_ready = (SKID == 1) ? (q.size() == 0 || ordy) : (q.size() < 2);
    chk("in_ready", in_ready, exp_ready);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) chk("fields", obs_vec(), exp_vec(q[0]));
`ifdef DECODE_ILLEGAL_TRAP_EN
    if (q.size() > 0) chk("out_illegal", out_illegal, q[0].ill);
    chk("illegal_seen", illegal_seen, seen_m);
`endif
    obs_acc = int'(in_valid && in_ready);
    obs_out = int'(out_valid && out_ready);
    if (fl) q.delete();
    else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (v && exp_ready) begin
        q.push_back(model(inst, pc & PCMASK));
        seen_m = seen_m | q[q.size()-1].ill;
      end
    end
  endtask

  initial begin
    int acc;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_fields", obs_vec(), 100'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", in_ready, 1'b1);

    // ORI r5,r0,0xFFFF at pc 0x100
    cycle(1'b1, 32'h3405_FFFF, 32'h100, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("ori_valid", out_valid, 1'b1);
    chk("ori_sel", out_alu_sel, 3'd0);
    chk("ori_op", out_alu_op, 8'd0);
    chk("ori_rd", out_rd, 5'd5);
    chk("ori_imm", out_imm, 32'h0000_FFFF);
    chk("ori_rw", out_reg_write, 1'b1);
    chk("ori_pc", 32'(out_pc), 32'h100);

    // BEQ with offset 0xFFFF
    cycle(1'b1, 32'h1022_FFFF, 32'h104, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("beq_op", out_alu_op, 8'd9);
    chk("beq_imm", out_imm, 32'hFFFF_FFFC);
    chk("beq_br", out_is_branch, 1'b1);
    chk("beq_rw", out_reg_write, 1'b0);

    // JAL index 0x40 at pc 0x00400000
    cycle(1'b1, 32'h0C00_0040, 32'h0040_0000, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("jal_imm", out_imm, 32'h0000_0100);
    chk("jal_rd", out_rd, 5'd31);
    chk("jal_jump", out_is_jump, 1'b1);
    chk("jal_rw", out_reg_write, 1'b1);

    // Back-pressure: three offers while stalled, then drain in order
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, rand_inst(), 32'h200 + 32'(i * 4), 1'b0, 1'b0);
      acc += obs_acc;
    end
    chk("skid_accepts", acc, (SKID == 1) ? 1 : 2);
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      acc += obs_out;
    end
    chk("skid_drained", acc, (SKID == 1) ? 1 : 2);

    // Flush with one entry held and a new offer in the same cycle
    cycle(1'b1, 32'h2008_0010, 32'h300, 1'b0, 1'b0);
    cycle(1'b1, 32'h3409_1234, 32'h304, 1'b0, 1'b1);
    @(posedge clk); #2;
    chk("flush_valid", out_valid, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic with stalls and occasional flushes
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // Unknown opcode 6'b111111
    cycle(1'b1, 32'hFC21_0042, 32'h400, 1'b1, 1'b0);
    @(posedge clk); #2;
    chk("bad_op", out_alu_op, 8'd21);
    chk("bad_rw", out_reg_write, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("bad_illegal", out_illegal, 1'b1);
    chk("bad_seen", illegal_seen, 1'b1);
`endif
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3405_0001, 32'h404 + 32'(i * 4), 1'b1, 1'b0);

    // Asynchronous reset while both entries are occupied
    cycle(1'b1, 32'h8C43_0008, 32'h500, 1'b0, 1'b0);
    cycle(1'b1, 32'hAC43_000C, 32'h504, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_fields", obs_vec(), 100'h0);
    chk("mid_rst_ready", in_ready, 1'b0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    chk("mid_rst_seen", illegal_seen, 1'b0);
    chk("mid_rst_illegal", out_illegal, 1'b0);
`endif
    q.delete();
    seen_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_release", in_ready, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, rand_inst(), 32'h600 + 32'(i * 4), 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
